// File: rtl/flow_pkg.sv
// flow_pkg: shared widths and helpers for the flow_* valid/ready pipeline blocks.
package flow_pkg;

  localparam int DWIDTH_8  = 8;
  localparam int DWIDTH_16 = 16;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flow_fifo_mem.sv
// flow_fifo_mem: DWIDTH x DEPTH register array, one write port, one
// asynchronous read port. Contents are deliberately not reset.
module flow_fifo_mem
  import flow_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_16,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] storage [DEPTH];

  // Write the addressed entry on an accepted, non-bypassed word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[wr_addr] <= wr_data;
    end
  end

  assign rd_data = storage[rd_addr];

endmodule

// File: rtl/flow_fifo.sv
// flow_fifo: valid/ready FIFO between flow_8to16 and flow_16to8.
// Optional macro FLOW_FIFO_BYPASS_EN adds a zero-latency path from src to
// dst while the FIFO is empty; without it there is no src-to-dst
// combinational path and a word appears the cycle after it is pushed.
module flow_fifo
  import flow_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_16,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic                          src_val,
  output logic                          src_rdy,
  input  logic [DWIDTH-1:0]             src_data,
  output logic                          dst_val,
  input  logic                          dst_rdy,
  output logic [DWIDTH-1:0]             dst_data,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              active;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop_mem;
  logic              wr_en;
  logic              bypass_take;
  logic [DWIDTH-1:0] mem_rd_data;

  // Outputs are held inactive while disabled or while reset is asserted.
  assign active  = cfg_en & rst_n;
  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign src_rdy = active & ~full;
  assign push    = src_val & src_rdy;

`ifdef FLOW_FIFO_BYPASS_EN
  assign dst_val     = active & (empty ? src_val : 1'b1);
  assign dst_data    = empty ? src_data : mem_rd_data;
  assign bypass_take = empty & push & dst_rdy;
`else
  assign dst_val     = active & ~empty;
  assign dst_data    = mem_rd_data;
  assign bypass_take = 1'b0;
`endif

  assign pop_mem = active & ~empty & dst_rdy;
  assign wr_en   = push & ~bypass_take;

  flow_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (src_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  // Pointer and occupancy update; reset or disable flushes to empty.
  always_ff @(posedge clk) begin
    if (!rst_n || !cfg_en) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_mem) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop_mem})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_fifo.sv
// tb_flow_fifo: directed vector table plus hand sequences for flow_fifo
// (DWIDTH=16, DEPTH=4). Honours FLOW_FIFO_BYPASS_EN when defined.
module tb_flow_fifo;

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic        src_val;
  logic        src_rdy;
  logic [15:0] src_data;
  logic        dst_val;
  logic        dst_rdy;
  logic [15:0] dst_data;
  logic [2:0]  level;

  int check_cnt;
  int pass_cnt;

  typedef struct {
    logic        rst_n;
    logic        cfg_en;
    logic        src_val;
    logic [15:0] src_data;
    logic        dst_rdy;
    logic        exp_src_rdy;
    logic        exp_dst_val;
    logic        chk_data;
    logic [15:0] exp_data;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t vecs[$];

  flow_fifo #(.DWIDTH(16), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .src_val  (src_val),
    .src_rdy  (src_rdy),
    .src_data (src_data),
    .dst_val  (dst_val),
    .dst_rdy  (dst_rdy),
    .dst_data (dst_data),
    .level    (level)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      pass_cnt++;
    end
  endtask

  // Drive inputs mid-cycle, then let combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic en, input logic sv,
                               input logic [15:0] sd, input logic dr);
    @(negedge clk);
    rst_n    = r;
    cfg_en   = en;
    src_val  = sv;
    src_data = sd;
    dst_rdy  = dr;
    #1;
  endtask

  task automatic addVector(input logic r, input logic en, input logic sv,
                           input logic [15:0] sd, input logic dr,
                           input logic esr, input logic edv, input logic cd,
                           input logic [15:0] ed, input logic [2:0] el);
    vec_t v;
    v.rst_n = r; v.cfg_en = en; v.src_val = sv; v.src_data = sd;
    v.dst_rdy = dr; v.exp_src_rdy = esr; v.exp_dst_val = edv;
    v.chk_data = cd; v.exp_data = ed; v.exp_level = el;
    vecs.push_back(v);
  endtask

  initial begin
    int          sent;
    int          recv;
    int          cycles;
    int          max_lvl;
    logic [15:0] cur_word;
    logic [15:0] exp_word;
    logic [15:0] sb[$];
    vec_t        v;
    logic        e_dv;
    logic        e_cd;
    logic [15:0] e_d;

    check_cnt = 0;
    pass_cnt  = 0;
    rst_n = 1'b0; cfg_en = 1'b1; src_val = 1'b0; src_data = '0; dst_rdy = 1'b0;
    repeat (2) @(posedge clk);

    //        rst en sv data     dr  srdy dval chk data     lvl
    addVector(0, 1, 0, 16'h0000, 0,  0,   0,   0,  16'h0000, 0);
    addVector(1, 1, 1, 16'h0001, 0,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 1, 16'h0002, 0,  1,   1,   1,  16'h0001, 1);
    addVector(1, 1, 1, 16'h0003, 0,  1,   1,   1,  16'h0001, 2);
    addVector(1, 1, 1, 16'h0004, 0,  1,   1,   1,  16'h0001, 3);
    addVector(1, 1, 1, 16'h0005, 0,  0,   1,   1,  16'h0001, 4);
    addVector(1, 1, 1, 16'h0005, 1,  0,   1,   1,  16'h0001, 4);
    addVector(1, 1, 1, 16'h0005, 1,  1,   1,   1,  16'h0002, 3);
    addVector(1, 1, 1, 16'h0006, 1,  1,   1,   1,  16'h0003, 3);
    addVector(1, 1, 0, 16'h0000, 1,  1,   1,   1,  16'h0004, 3);
    addVector(1, 1, 0, 16'h0000, 1,  1,   1,   1,  16'h0005, 2);
    addVector(1, 1, 0, 16'h0000, 1,  1,   1,   1,  16'h0006, 1);
    addVector(1, 1, 0, 16'h0000, 1,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 0, 16'h0000, 1,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 1, 16'h0011, 0,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 1, 16'h0022, 0,  1,   1,   1,  16'h0011, 1);
    addVector(1, 1, 1, 16'h0033, 0,  1,   1,   1,  16'h0011, 2);
    addVector(1, 1, 0, 16'h0000, 0,  1,   1,   1,  16'h0011, 3);
    addVector(1, 0, 0, 16'h0000, 0,  0,   0,   0,  16'h0000, 3);
    addVector(1, 1, 1, 16'h00AA, 0,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 0, 16'h0000, 1,  1,   1,   1,  16'h00AA, 1);
    addVector(1, 1, 0, 16'h0000, 0,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 1, 16'h0077, 0,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 1, 16'h0088, 0,  1,   1,   1,  16'h0077, 1);
    addVector(0, 1, 0, 16'h0000, 0,  0,   0,   0,  16'h0000, 2);
    addVector(1, 1, 0, 16'h0000, 1,  1,   0,   0,  16'h0000, 0);
    addVector(1, 1, 0, 16'h0000, 1,  1,   0,   0,  16'h0000, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      e_dv = v.exp_dst_val;
      e_cd = v.chk_data;
      e_d  = v.exp_data;
`ifdef FLOW_FIFO_BYPASS_EN
      if (v.exp_level == 3'd0 && v.rst_n && v.cfg_en && v.src_val) begin
        e_dv = 1'b1;
        e_cd = 1'b1;
        e_d  = v.src_data;
      end
`endif
      applyStimulus(v.rst_n, v.cfg_en, v.src_val, v.src_data, v.dst_rdy);
      checkOutput($sformatf("row%0d src_rdy", i), 32'(src_rdy), 32'(v.exp_src_rdy));
      checkOutput($sformatf("row%0d dst_val", i), 32'(dst_val), 32'(e_dv));
      checkOutput($sformatf("row%0d level", i), 32'(level), 32'(v.exp_level));
      if (e_cd) begin
        checkOutput($sformatf("row%0d dst_data", i), 32'(dst_data), 32'(e_d));
      end
    end

    // Empty FIFO offered a word with the sink ready: latency depends on bypass.
    applyStimulus(1, 1, 1, 16'h005A, 1);
`ifdef FLOW_FIFO_BYPASS_EN
    checkOutput("bypass dst_val", 32'(dst_val), 32'd1);
    checkOutput("bypass dst_data", 32'(dst_data), 32'h5A);
    checkOutput("bypass level", 32'(level), 32'd0);
    applyStimulus(1, 1, 0, 16'h0000, 1);
    checkOutput("bypass after dst_val", 32'(dst_val), 32'd0);
    checkOutput("bypass after level", 32'(level), 32'd0);
`else
    checkOutput("latency dst_val same", 32'(dst_val), 32'd0);
    checkOutput("latency level same", 32'(level), 32'd0);
    applyStimulus(1, 1, 0, 16'h0000, 1);
    checkOutput("latency dst_val next", 32'(dst_val), 32'd1);
    checkOutput("latency dst_data next", 32'(dst_data), 32'h5A);
    checkOutput("latency level next", 32'(level), 32'd1);
`endif
    applyStimulus(1, 1, 0, 16'h0000, 1);
    checkOutput("drain dst_val", 32'(dst_val), 32'd0);
    checkOutput("drain level", 32'(level), 32'd0);

    // Continuous streaming of 1000 random words against a queue model.
    sent = 0; recv = 0; cycles = 0; max_lvl = 0;
    cur_word = 16'($urandom_range(0, 65535));
    while (recv < 1000 && cycles < 3000) begin
      applyStimulus(1, 1, (sent < 1000), cur_word, 1);
      cycles++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (src_val && src_rdy) begin
        sb.push_back(cur_word);
        sent++;
        cur_word = 16'($urandom_range(0, 65535));
      end
      if (dst_val && dst_rdy) begin
        if (sb.size() == 0) begin
          checkOutput("stream underflow", 32'(dst_data), 32'hFFFF_FFFF);
        end else begin
          exp_word = sb.pop_front();
          checkOutput($sformatf("stream word%0d", recv), 32'(dst_data), 32'(exp_word));
        end
        recv++;
      end
    end
    checkOutput("stream received count", 32'(recv), 32'd1000);
`ifdef FLOW_FIFO_BYPASS_EN
    checkOutput("stream max level", 32'(max_lvl), 32'd0);
`else
    checkOutput("stream max level", 32'(max_lvl), 32'd1);
`endif
    applyStimulus(1, 1, 0, 16'h0000, 1);
    checkOutput("stream final level", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/flow_fifo.md
FLOW_FIFO -- requirements
Module: flow_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data width in bits (8 or 16; placed downstream of flow_8to16, upstream of flow_16to8).
REQ-002 SHALL have parameter DEPTH, default 4, storage entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active low.
REQ-005 SHALL have port cfg_en  input  1  enable, active high; protocol may be violated while low.
REQ-006 SHALL have port src_val  input  1  upstream valid, active high.
REQ-007 SHALL have port src_rdy  output  1  upstream ready, active high.
REQ-008 SHALL have port src_data  input  DWIDTH  upstream data, steady while src_val high.
REQ-009 SHALL have port dst_val  output  1  downstream valid, active high.
REQ-010 SHALL have port dst_rdy  input  1  downstream ready, active high.
REQ-011 SHALL have port dst_data  output  DWIDTH  downstream data, steady while dst_val high and dst_rdy low.
REQ-012 SHALL have port level  output  $clog2(DEPTH+1)  stored-entry count.

Function
REQ-013 Push = src_val & src_rdy; pop = dst_val & dst_rdy; both sampled on the same rising edge.
REQ-014 src_rdy SHALL be cfg_en & (level != DEPTH); no dependence on dst_rdy (no combinational ready path).
REQ-015 dst_val SHALL be cfg_en & (level != 0) in the base build; dst_data SHALL be the entry at the read pointer.
REQ-016 Data SHALL leave in strict arrival order; no loss, no duplication.
REQ-017 Base latency: word pushed at edge N is presented with dst_val high from the cycle after edge N.
REQ-018 Simultaneous push and pop SHALL leave level unchanged; both pointers advance.
REQ-019 Full (level == DEPTH): src_rdy low, even if a pop happens that cycle; push resumes the cycle after the pop.
REQ-020 Empty (level == 0): dst_val low; a pop attempt is ignored.
REQ-021 Read/write pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0 without gaps.
REQ-022 dst_val, once high, SHALL stay high with dst_data stable until popped (unless cfg_en falls or reset).
REQ-023 cfg_en low at an edge SHALL flush: pointers and level cleared; src_rdy and dst_val low while cfg_en low.
REQ-024 cfg_en rising SHALL start from empty; no stale data presented.

Reset
REQ-025 rst_n low at an edge SHALL clear read pointer, write pointer and level to 0.
REQ-026 During/after reset: src_rdy 0 (while rst_n low), dst_val 0, level 0; dst_data don't-care while dst_val 0.
REQ-027 Reset mid-transfer SHALL discard all stored words; storage array not reset.

Configuration
REQ-028 Macro FLOW_FIFO_BYPASS_EN SHALL compile in zero-latency bypass.
REQ-029 With it: when level == 0 and cfg_en, dst_val = src_val and dst_data = src_data combinationally; if dst_rdy also high, word is consumed without being written and level stays 0.
REQ-030 With it: if level == 0 and dst_rdy low, word is written as in base build.
REQ-031 Without it: REQ-015/REQ-017 hold exactly; no src-to-dst combinational path.

Structure
REQ-032 Package flow_pkg SHALL hold DWIDTH_8 = 8, DWIDTH_16 = 16 and the level-width helper constant/function.
REQ-033 Storage SHALL be sub-module flow_fifo_mem (DWIDTH x DEPTH register array, 1 write port, 1 asynchronous read port); pointers/level in flow_fifo.

Verification (master_vldrdy source, slave_vldrdy sink, vld_rdy_checker on both sides)
REQ-034 DEPTH=4, dst_rdy held 0, push 0x0001..0x0006 -> 4 accepted, level 4, src_rdy 0; dst_rdy to 1 -> out 0x0001..0x0006 in order.
REQ-035 Full, src_val and dst_rdy both 1 for one cycle -> pop only, level 3; next cycle push accepted, level stays 3 with concurrent pop.
REQ-036 Continuous src_val/dst_rdy, 1000 random words -> output sequence identical, level never exceeds 1, checkers clean, 3 full pointer wraps minimum.
REQ-037 Level 3, cfg_en dropped 1 cycle -> level 0, dst_val 0; re-enable, push 0x00AA -> first output 0x00AA.
REQ-038 rst_n low 1 cycle at level 2 -> level 0, dst_val 0 next cycle; no old word emitted.
REQ-039 FLOW_FIFO_BYPASS_EN defined, empty, src_val=1, src_data=0x5A, dst_rdy=1 -> dst_val=1, dst_data=0x5A same cycle, level stays 0; undefined -> dst_val rises one cycle later.
